// File: rtl/synapse_integrator_if.sv
// Purpose : bundles the spike, weight-write, parameter-write and output signals of synapse_integrator.
// Latency : n/a (wiring only).
// Backpressure: none; every signal is sampled or driven on every clock edge.
//
// Signals (master = stimulus side, slave = integrator):
//   spike_in        [N_IN]         one bit per presynaptic spike
//   load_w, w_addr, w_data         weight write strobe, index, signed value
//   load_params, new_decay_shift,
//   new_I_max, new_I_min           parameter write strobe and new values
//   clr_sat                        clears the sticky saturation flag
//   I_out           [WIDTH] signed registered synaptic current
//   sat_flag                       sticky saturation indicator
interface synapse_integrator_if #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4
);
    localparam int AW = $clog2(N_IN);

    logic        [N_IN-1:0]  spike_in;
    logic                    load_w;
    logic        [AW-1:0]    w_addr;
    logic signed [WIDTH-1:0] w_data;
    logic                    load_params;
    logic        [3:0]       new_decay_shift;
    logic signed [WIDTH-1:0] new_I_max;
    logic signed [WIDTH-1:0] new_I_min;
    logic                    clr_sat;
    logic signed [WIDTH-1:0] I_out;
    logic                    sat_flag;

    modport master (
        output spike_in, load_w, w_addr, w_data,
        output load_params, new_decay_shift, new_I_max, new_I_min,
        output clr_sat,
        input  I_out, sat_flag
    );

    modport slave (
        input  spike_in, load_w, w_addr, w_data,
        input  load_params, new_decay_shift, new_I_max, new_I_min,
        input  clr_sat,
        output I_out, sat_flag
    );
endinterface

// File: rtl/synapse_integrator.sv
// Purpose : leaky synaptic current integrator; sums weights of spiking inputs, decays by arithmetic shift, clamps.
// Latency : one cycle from spike_in sample to I_out.
// Backpressure: none; a new update is accepted on every clock edge.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (I_out=0, weights=0, shift=4, full-range bounds, flag clear)
//   bus  - synapse_integrator_if.slave (spikes, weight/parameter writes, clr_sat, I_out, sat_flag)
// Build option: define SYN_SAT_FLAG_EN to include the sticky saturation flag; otherwise sat_flag is 0.
module synapse_integrator #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    synapse_integrator_if.slave  bus
);

    localparam int AW = $clog2(N_IN);
    // Headroom: one bit for I_out - D, AW bits for the spike sum, one spare.
    // Nothing can wrap before the clamp.
    localparam int SW = WIDTH + AW + 2;

    localparam logic signed [WIDTH-1:0] I_MAX_RST = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] I_MIN_RST = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] r_weight [N_IN];
    logic signed [WIDTH-1:0] r_I_out;
    logic signed [WIDTH-1:0] r_I_max;
    logic signed [WIDTH-1:0] r_I_min;
    logic        [3:0]       r_decay_shift;

    logic signed [WIDTH-1:0] w_decay;
    logic signed [SW-1:0]    w_spike_sum;
    logic signed [SW-1:0]    w_next_wide;
    logic                    w_above;
    logic                    w_below;
    logic signed [WIDTH-1:0] w_I_next;
    logic                    w_params_ok;
    logic        [3:0]       w_shift_lim;

    // Shift of zero means "no leak", not "subtract everything".
    always_comb begin
        w_decay = '0;
        if (r_decay_shift != 4'd0) begin
            w_decay = r_I_out >>> r_decay_shift;
        end
    end

    // All spiking inputs contribute in the same cycle, using the weights
    // held before any same-cycle weight write.
    always_comb begin
        w_spike_sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (bus.spike_in[k]) begin
                w_spike_sum = w_spike_sum + SW'(r_weight[k]);
            end
        end
    end

    assign w_next_wide = SW'(r_I_out) - SW'(w_decay) + w_spike_sum;
    assign w_above     = (w_next_wide > SW'(r_I_max));
    assign w_below     = (w_next_wide < SW'(r_I_min));

    always_comb begin
        w_I_next = w_next_wide[WIDTH-1:0];
        if (w_above) begin
            w_I_next = r_I_max;
        end else if (w_below) begin
            w_I_next = r_I_min;
        end
    end

    // An inverted bound pair is rejected as a whole; oversized shifts saturate
    // at WIDTH-1 so the leak never exceeds the value itself.
    assign w_params_ok = (bus.new_I_min <= bus.new_I_max);
    assign w_shift_lim = (int'(bus.new_decay_shift) >= WIDTH) ? 4'(WIDTH - 1)
                                                               : bus.new_decay_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_I_out       <= '0;
            r_decay_shift <= 4'd4;
            r_I_max       <= I_MAX_RST;
            r_I_min       <= I_MIN_RST;
        end else begin
            r_I_out <= w_I_next;
            if (bus.load_params && w_params_ok) begin
                r_decay_shift <= w_shift_lim;
                r_I_max       <= bus.new_I_max;
                r_I_min       <= bus.new_I_min;
            end
        end
    end

    // Address decode by exact match only, so indices >= N_IN select nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++) begin
                r_weight[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                if (bus.load_w && (bus.w_addr == AW'(k))) begin
                    r_weight[k] <= bus.w_data;
                end
            end
        end
    end

    assign bus.I_out = r_I_out;

`ifdef SYN_SAT_FLAG_EN
    logic r_sat_flag;

    // New saturation wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
        end else if (w_above || w_below) begin
            r_sat_flag <= 1'b1;
        end else if (bus.clr_sat) begin
            r_sat_flag <= 1'b0;
        end
    end

    assign bus.sat_flag = r_sat_flag;
`else
    logic w_unused_clr_sat;

    assign w_unused_clr_sat = bus.clr_sat;
    assign bus.sat_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_synapse_integrator.sv
module tb_synapse_integrator;

    localparam int WIDTH = 16;
    localparam int N_IN  = 4;
    localparam int MX    = 32767;
    localparam int MN    = -32768;
`ifdef SYN_SAT_FLAG_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    typedef struct {
        logic [3:0]         spike;
        logic               lw;
        logic [1:0]         addr;
        logic signed [15:0] wd;
        logic               lp;
        logic [3:0]         sh;
        logic signed [15:0] mx;
        logic signed [15:0] mn;
        logic               clr;
        int                 exp_i;
        logic               exp_s;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t tbl[$];

    synapse_integrator_if #(.WIDTH(WIDTH), .N_IN(N_IN)) u_if ();

    synapse_integrator #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int sp, input int lw, input int a, input int wd,
                                input int lp, input int sh, input int mx, input int mn,
                                input int clr, input int ei, input bit es);
        vec_t v;
        v.spike = 4'(sp);
        v.lw    = 1'(lw);
        v.addr  = 2'(a);
        v.wd    = 16'(wd);
        v.lp    = 1'(lp);
        v.sh    = 4'(sh);
        v.mx    = 16'(mx);
        v.mn    = 16'(mn);
        v.clr   = 1'(clr);
        v.exp_i = ei;
        v.exp_s = es;
        return v;
    endfunction

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        u_if.spike_in        = v.spike;
        u_if.load_w          = v.lw;
        u_if.w_addr          = v.addr;
        u_if.w_data          = v.wd;
        u_if.load_params     = v.lp;
        u_if.new_decay_shift = v.sh;
        u_if.new_I_max       = v.mx;
        u_if.new_I_min       = v.mn;
        u_if.clr_sat         = v.clr;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));

        //          sp lw a  wd      lp sh mx    mn      clr  I_out   sat
        tbl.push_back(mk(0, 1, 0, 1000,   1, 0, MX,   MN,     0,   0,      1'b0)); // shift=0, w0=1000
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,    0,      0,   1000,   1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   1000,   1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   1000,   1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 1, MX,   MN,     0,   1000,   1'b0)); // old shift used
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   500,    1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   250,    1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   125,    1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   63,     1'b0));
        tbl.push_back(mk(0, 1, 0, 20000,  1, 0, MX,   MN,     0,   32,     1'b0)); // both strobes
        tbl.push_back(mk(0, 1, 1, 20000,  0, 0, 0,    0,      0,   32,     1'b0));
        tbl.push_back(mk(0, 1, 2, 20000,  0, 0, 0,    0,      0,   32,     1'b0));
        tbl.push_back(mk(0, 1, 3, 20000,  0, 0, 0,    0,      0,   32,     1'b0));
        tbl.push_back(mk(15, 0, 0, 0,     0, 0, 0,    0,      0,   MX,     S));    // 4 spikes saturate
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   MX,     S));    // sticky
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      1,   MX,     1'b0)); // clr
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,    0,      1,   MX,     S));    // clr + new sat
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      1,   MX,     1'b0));
        tbl.push_back(mk(0, 1, 1, -20000, 0, 0, 0,    0,      0,   MX,     1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, 0,    0,      0,   MX,     1'b0)); // bounds 0..0
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   0,      S));    // clamped in
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, MX,   -30000, 1,   0,      1'b0));
        tbl.push_back(mk(2, 0, 0, 0,      0, 0, 0,    0,      0,   -20000, 1'b0));
        tbl.push_back(mk(2, 0, 0, 0,      0, 0, 0,    0,      0,   -30000, S));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      1,   -30000, 1'b0));
        tbl.push_back(mk(0, 1, 0, 1000,   1, 0, 0,    0,      0,   -30000, 1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 0, MX,   MN,     0,   0,      S));
        tbl.push_back(mk(1, 1, 0, 500,    0, 0, 0,    0,      1,   1000,   1'b0)); // old weight used
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,    0,      0,   1500,   1'b0)); // new weight
        tbl.push_back(mk(0, 0, 0, 0,      1, 5, 50,   100,    0,   1500,   1'b0)); // inverted: ignored
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   1500,   1'b0)); // shift still 0
        tbl.push_back(mk(9, 0, 0, 0,      0, 0, 0,    0,      0,   22000,  1'b0));
        tbl.push_back(mk(6, 0, 0, 0,      0, 0, 0,    0,      0,   22000,  1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 15, MX,  MN,     0,   22000,  1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   22000,  1'b0));
        tbl.push_back(mk(2, 0, 0, 0,      0, 0, 0,    0,      0,   2000,   1'b0));
        tbl.push_back(mk(2, 0, 0, 0,      0, 0, 0,    0,      0,   -18000, 1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 2, MX,   MN,     0,   -17999, 1'b0)); // -18000>>>15 = -1
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   -13499, 1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 2, 5000, 5000,   0,   -10124, 1'b0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   5000,   S));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,    0,      0,   5000,   S));

        repeat (2) @(posedge clk);
        #1;
        check("reset_I_out", u_if.I_out, 0);
        check("reset_sat", {31'd0, u_if.sat_flag}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_I_out", i), u_if.I_out, tbl[i].exp_i);
            check($sformatf("row%0d_sat", i), {31'd0, u_if.sat_flag}, {31'd0, tbl[i].exp_s});
        end

        // Asynchronous reset between edges, with strobes and spikes in flight.
        @(negedge clk);
        drive(mk(15, 1, 0, 7777, 1, 7, 100, -100, 0, 0, 1'b0));
        #2;
        check("pre_rst_I_out", u_if.I_out, 5000);
        rst = 1'b1;
        #1;
        check("async_rst_I_out", u_if.I_out, 0);
        check("async_rst_sat", {31'd0, u_if.sat_flag}, 0);
        @(posedge clk);
        #1;
        check("held_rst_I_out", u_if.I_out, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));
        @(posedge clk);
        #1;
        check("post_rst_spike1", u_if.I_out, 0);
        @(posedge clk);
        #1;
        check("post_rst_spike2", u_if.I_out, 0);

        // Reset defaults: shift 4 and full-range bounds.
        @(negedge clk);
        drive(mk(0, 1, 0, 1000, 0, 0, 0, 0, 0, 0, 1'b0));
        @(posedge clk);
        #1;
        check("dflt_load_I_out", u_if.I_out, 0);
        @(negedge clk);
        drive(mk(1, 1, 1, 32767, 0, 0, 0, 0, 0, 0, 1'b0));
        @(posedge clk);
        #1;
        check("dflt_spike_I_out", u_if.I_out, 1000);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));
        @(posedge clk);
        #1;
        check("dflt_shift4_I_out", u_if.I_out, 938);
        @(negedge clk);
        drive(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));
        @(posedge clk);
        #1;
        check("dflt_imax_I_out", u_if.I_out, MX);
        check("dflt_imax_sat", {31'd0, u_if.sat_flag}, {31'd0, S});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
